// File: rtl/io_pkg.sv
// Shared I/O constants for the memory-mapped board peripherals.
package io_pkg;
  localparam int          N_SW_DEFAULT        = 10;
  localparam logic [31:0] SW_ADDR             = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR            = 32'hC000_0004;
  localparam int          DEBOUNCE_10MS_50MHZ = 500000;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: multi-flop synchronizer followed by a restart-on-glitch debounce counter.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_raw,
  output logic q,
  output logic changed,
  output logic changed_nxt
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   r_changed;
  logic                   w_sync;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_q_nxt;
  logic                   w_chg_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Any return to the accepted level clears the count: no partial credit.
  always_comb begin
    w_cnt_nxt = '0;
    w_q_nxt   = r_q;
    w_chg_nxt = 1'b0;
    if (w_sync != r_q) begin
      if (r_cnt == TERM) begin
        w_q_nxt   = w_sync;
        w_chg_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], d_raw};
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_changed <= w_chg_nxt;
    end
  end

  assign q           = r_q;
  assign changed     = r_changed;
  // Pre-register strobe so the parent can register an aggregate aligned with changed.
  assign changed_nxt = w_chg_nxt;
endmodule

// File: rtl/switch_conditioner.sv
// Synchronizes and debounces the board slide switches for the dmem switch port.
module switch_conditioner
  import io_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] switches,
  output logic [N_SW-1:0] sw_changed,
  output logic            sw_event
);
  logic [N_SW-1:0] w_chg_nxt;
  logic            r_event;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk),
      .reset_n    (reset_n),
      .d_raw      (sw_raw[i]),
      .q          (switches[i]),
      .changed    (sw_changed[i]),
      .changed_nxt(w_chg_nxt[i])
    );
  end

  // Registered from the next-state strobes so it lands in the same cycle as sw_changed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_event <= 1'b0;
    else          r_event <= |w_chg_nxt;
  end

  assign sw_event = r_event;
endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: directed scenarios plus random switch activity.
module tb_switch_conditioner;
  localparam int N    = 10;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  typedef struct packed {
    logic [N-1:0] sw;
    logic [N-1:0] ch;
    logic         ev;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] sw_raw = '1;
  logic [N-1:0] switches, sw_changed;
  logic         sw_event;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  exp_t sbq[$];

  switch_conditioner #(.N_SW(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .switches  (switches),
    .sw_changed(sw_changed),
    .sw_event  (sw_event)
  );

  always #5 clk = ~clk;

  // Reference model: a bit accepts a new level once the synchronized input has
  // disagreed with the accepted level on each of the last DEB edges since reset.
  initial begin
    logic [N-1:0] hist[$];
    logic [N-1:0] shist[$];
    logic [N-1:0] msw, mch, sv;
    bit           all;
    msw = '0;
    for (int k = 0; k < SYNC; k++) hist.push_back('0);
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        msw = '0;
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        shist.delete();
        sbq.push_back('{sw: '0, ch: '0, ev: 1'b0});
      end else begin
        hist.push_back(sw_raw);
        sv = hist[hist.size()-1-SYNC];
        while (hist.size() > SYNC + 1) void'(hist.pop_front());
        shist.push_back(sv);
        while (shist.size() > DEB) void'(shist.pop_front());
        mch = '0;
        if (shist.size() == DEB) begin
          for (int b = 0; b < N; b++) begin
            all = 1'b1;
            for (int j = 0; j < DEB; j++) if (shist[j][b] == msw[b]) all = 1'b0;
            mch[b] = all;
          end
        end
        msw = msw ^ mch;
        sbq.push_back('{sw: msw, ch: mch, ev: |mch});
      end
    end
  end

  // Monitor: the DUT presents a result every cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      n_tot++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_empty cyc=%0d: no expected entry for DUT output", cyc);
      end else begin
        e = sbq.pop_front();
        if (switches === e.sw && sw_changed === e.ch && sw_event === e.ev)
          n_pass++;
        else
          $display("FAIL outputs cyc=%0d: sw=%h ch=%h ev=%b, expected sw=%h ch=%h ev=%b",
                   cyc, switches, sw_changed, sw_event, e.sw, e.ch, e.ev);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold;
    // 1: reset held with all pins high, then release
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(12);
    // 2: clean step on bit 0
    sw_raw = '0;
    wait_cyc(10);
    sw_raw[0] = 1'b1;
    wait_cyc(10);
    // 3: 3-cycle glitch on bit 3
    sw_raw[3] = 1'b1;
    wait_cyc(3);
    sw_raw[3] = 1'b0;
    wait_cyc(10);
    // 4: bounce then settle on bit 5
    for (int k = 0; k < 5; k++) begin
      sw_raw[5] = ~k[0];
      wait_cyc(1);
    end
    wait_cyc(10);
    // 5: simultaneous multi-bit step
    sw_raw = '0;
    wait_cyc(10);
    sw_raw = 10'h2A5;
    wait_cyc(10);
    // 6: reset asserted mid-debounce of bit 9
    sw_raw = '0;
    wait_cyc(10);
    sw_raw = 10'h200;
    wait_cyc(3);
    #2 reset_n = 1'b0;
    #1;
    n_tot++;
    if (switches === '0 && sw_changed === '0 && sw_event === 1'b0)
      n_pass++;
    else
      $display("FAIL async_reset: sw=%h ch=%h ev=%b, expected all zero",
               switches, sw_changed, sw_event);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(10);
    // random activity, including short glitches and one random reset
    hold = 1;
    for (int c = 0; c < 800; c++) begin
      if (--hold == 0) begin
        sw_raw = sw_raw ^ N'($urandom & $urandom);
        hold   = int'($urandom_range(1, 8));
      end
      if (c == 400) reset_n = 1'b0;
      if (c == 403) reset_n = 1'b1;
      wait_cyc(1);
    end
    wait_cyc(12);
    wait_cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
